// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampling UART receiver with optional parity.
// Ports: clk, rst (async, active-high), rx (serial in, idles high);
//        rx_frame (data word, LSB first on wire), rx_done (1-clk strobe),
//        frame_error (stop/parity error of the latest frame).
module uart_rx_os #(
    parameter int    CLK_FREQUENCE = 50_000_000,
    parameter int    BAUD_RATE     = 9600,
    parameter string PARITY        = "NONE",
    parameter int    FRAME_WD      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx,
    output logic [FRAME_WD-1:0] rx_frame,
    output logic                rx_done,
    output logic                frame_error
);

    localparam int OS_DIV = (CLK_FREQUENCE + BAUD_RATE * 8)
                          / (BAUD_RATE * 16);
    localparam int DIV_W  = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam int BIT_W  = $clog2(FRAME_WD);
    localparam bit PAR_EN  = (PARITY != "NONE");
    localparam bit PAR_ODD = (PARITY == "ODD");

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OS_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_WD - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PAR, STOP, BRK
    } state_t;

    state_t state, state_nxt;

    logic                rx_meta, rxs, rxs_d;
    logic                fall;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [3:0]          smp_cnt;
    logic [1:0]          early;
    logic                vote;
    logic                at_vote, at_wrap;
    logic [BIT_W-1:0]    bit_cnt;
    logic [FRAME_WD-1:0] shift_q;
    logic                par_err;
    logic                start_det, shift_en, par_en, done_en;

    // Two-stage synchronizer plus one more stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    assign fall    = rxs_d & ~rxs;
    assign tick    = (div_cnt == DIV_LAST);
    assign at_vote = tick && (smp_cnt == 4'd9);
    assign at_wrap = tick && (smp_cnt == 4'd15);

    // 2-of-3 over samples 7, 8 and the live sample 9.
    assign vote = (early[0] & early[1])
                | (early[0] & rxs)
                | (early[1] & rxs);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (fall) state_nxt = START;
            end
            START: begin
                if (at_vote && vote) state_nxt = IDLE;
                else if (at_wrap)    state_nxt = DATA;
            end
            DATA: begin
                if (at_wrap && (bit_cnt == BIT_LAST))
                    state_nxt = PAR_EN ? PAR : STOP;
            end
            PAR: begin
                if (at_wrap) state_nxt = STOP;
            end
            STOP: begin
                // Leave at mid-stop so a back-to-back start is caught.
                if (at_vote) state_nxt = vote ? IDLE : BRK;
            end
            BRK: begin
                if (rxs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / strobe decode
    always_comb begin
        start_det = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        done_en   = 1'b0;
        unique case (state)
            IDLE:    start_det = fall;
            DATA:    shift_en  = at_vote;
            PAR:     par_en    = at_vote;
            STOP:    done_en   = at_vote;
            default: ;
        endcase
    end

    // Tick divider is realigned to the start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else if (start_det) begin
            div_cnt <= '0;
            smp_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            smp_cnt <= smp_cnt + 4'd1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            early <= 2'b00;
        end else if (tick) begin
            if (smp_cnt == 4'd7) early[0] <= rxs;
            if (smp_cnt == 4'd8) early[1] <= rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                bit_cnt <= '0;
        else if (state != DATA) bit_cnt <= '0;
        else if (at_wrap)       bit_cnt <= bit_cnt + BIT_W'(1);
    end

    // LSB arrives first, so shift in from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            shift_q <= '0;
        else if (shift_en)
            shift_q <= {vote, shift_q[FRAME_WD-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par_err <= 1'b0;
        else if (start_det)
            par_err <= 1'b0;
        else if (par_en)
            par_err <= PAR_ODD ? ~(^shift_q ^ vote)
                               :  (^shift_q ^ vote);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_frame    <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_done <= done_en;
            if (done_en) begin
                rx_frame    <= shift_q;
                frame_error <= ~vote | par_err;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os, one 8N1 and one 8E1
// receiver driven from separate serial lines.
`timescale 1ns/1ps
module tb_uart_rx_os;

    localparam int CLK_F = 1_536_000;
    localparam int BAUD  = 9600;
    localparam int BIT   = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [7:0] frame_a, frame_b;
    logic       done_a, done_b;
    logic       err_a, err_b;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    int cnt_a = 0, cnt_b = 0;
    int wide_a = 0, wide_b = 0;
    logic pa = 1'b0, pb = 1'b0;
    logic [7:0] log_fa [0:31];
    logic [7:0] log_fb [0:31];
    logic       log_ea [0:31];
    logic       log_eb [0:31];
    int base;

    uart_rx_os #(
        .CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD),
        .PARITY("NONE"), .FRAME_WD(8)
    ) u_n (
        .clk(clk), .rst(rst), .rx(rx_a),
        .rx_frame(frame_a), .rx_done(done_a), .frame_error(err_a)
    );

    uart_rx_os #(
        .CLK_FREQUENCE(CLK_F), .BAUD_RATE(BAUD),
        .PARITY("EVEN"), .FRAME_WD(8)
    ) u_e (
        .clk(clk), .rst(rst), .rx(rx_b),
        .rx_frame(frame_b), .rx_done(done_b), .frame_error(err_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a) begin
            if (cnt_a < 32) begin
                log_fa[cnt_a] = frame_a;
                log_ea[cnt_a] = err_a;
            end
            cnt_a++;
        end
        if (done_a && pa) wide_a++;
        pa = done_a;
        if (done_b) begin
            if (cnt_b < 32) begin
                log_fb[cnt_b] = frame_b;
                log_eb[cnt_b] = err_b;
            end
            cnt_b++;
        end
        if (done_b && pb) wide_b++;
        pb = done_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input bit which, input logic v);
        if (which) rx_b = v;
        else       rx_a = v;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send(input bit which, input logic [7:0] d,
                        input bit par_on, input logic par,
                        input logic stop);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (par_on) drive_bit(which, par);
        drive_bit(which, stop);
    endtask

    initial begin
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_frame_a", 32'(frame_a), 32'h0);
        chk("rst_done_a", 32'(done_a), 32'h0);
        chk("rst_err_a", 32'(err_a), 32'h0);
        chk("rst_frame_b", 32'(frame_b), 32'h0);
        chk("rst_err_b", 32'(err_b), 32'h0);
        rst = 1'b0;
        repeat (2 * BIT) @(negedge clk);

        // single 8N1 frame
        base = cnt_a;
        send(1'b0, 8'h2B, 1'b0, 1'b0, 1'b1);
        chk("t1_count", 32'(cnt_a - base), 32'd1);
        chk("t1_frame", 32'(log_fa[base]), 32'h2B);
        chk("t1_err", 32'(log_ea[base]), 32'h0);
        chk("t1_hold", 32'(frame_a), 32'h2B);
        drive_bit(1'b0, 1'b1);

        // back-to-back, no idle between frames
        base = cnt_a;
        send(1'b0, 8'h2B, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h35, 1'b0, 1'b0, 1'b1);
        chk("b2b_count", 32'(cnt_a - base), 32'd2);
        chk("b2b_frame0", 32'(log_fa[base]), 32'h2B);
        chk("b2b_err0", 32'(log_ea[base]), 32'h0);
        chk("b2b_frame1", 32'(log_fa[base + 1]), 32'h35);
        chk("b2b_err1", 32'(log_ea[base + 1]), 32'h0);
        drive_bit(1'b0, 1'b1);

        // even parity: 0x2B has four ones, so parity 1 is wrong
        base = cnt_b;
        send(1'b1, 8'h2B, 1'b1, 1'b1, 1'b1);
        chk("par_bad_count", 32'(cnt_b - base), 32'd1);
        chk("par_bad_frame", 32'(log_fb[base]), 32'h2B);
        chk("par_bad_err", 32'(log_eb[base]), 32'h1);
        send(1'b1, 8'h35, 1'b1, 1'b0, 1'b1);
        chk("par_ok_count", 32'(cnt_b - base), 32'd2);
        chk("par_ok_frame", 32'(log_fb[base + 1]), 32'h35);
        chk("par_ok_err", 32'(log_eb[base + 1]), 32'h0);
        drive_bit(1'b1, 1'b1);

        // stop bit low, line held low three bit times
        base = cnt_a;
        send(1'b0, 8'hC3, 1'b0, 1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b0);
        chk("brk_count", 32'(cnt_a - base), 32'd1);
        chk("brk_frame", 32'(log_fa[base]), 32'hC3);
        chk("brk_err", 32'(log_ea[base]), 32'h1);
        drive_bit(1'b0, 1'b1);
        send(1'b0, 8'h35, 1'b0, 1'b0, 1'b1);
        chk("brk_next_count", 32'(cnt_a - base), 32'd2);
        chk("brk_next_frame", 32'(log_fa[base + 1]), 32'h35);
        chk("brk_next_err", 32'(log_ea[base + 1]), 32'h0);
        drive_bit(1'b0, 1'b1);

        // 20 us low glitch (~31 clocks at 1.536 MHz)
        base = cnt_a;
        rx_a = 1'b0;
        repeat (31) @(negedge clk);
        rx_a = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        chk("glitch_count", 32'(cnt_a - base), 32'd0);
        send(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        chk("glitch_next_count", 32'(cnt_a - base), 32'd1);
        chk("glitch_next_frame", 32'(log_fa[base]), 32'h55);
        chk("glitch_next_err", 32'(log_ea[base]), 32'h0);
        drive_bit(1'b0, 1'b1);

        // reset after four data bits of 0xA5
        base = cnt_a;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_frame_a", 32'(frame_a), 32'h0);
        chk("rst_mid_done_a", 32'(done_a), 32'h0);
        chk("rst_mid_err_a", 32'(err_a), 32'h0);
        chk("rst_mid_frame_b", 32'(frame_b), 32'h0);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        rx_a = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst = 1'b0;
        repeat (BIT / 2) @(negedge clk);
        drive_bit(1'b0, 1'b1);
        chk("rst_no_done", 32'(cnt_a - base), 32'd0);
        send(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        chk("rst_next_count", 32'(cnt_a - base), 32'd1);
        chk("rst_next_frame", 32'(log_fa[base]), 32'h3C);
        chk("rst_next_err", 32'(log_ea[base]), 32'h0);
        drive_bit(1'b0, 1'b1);

        chk("pulse_width_a", 32'(wide_a), 32'd0);
        chk("pulse_width_b", 32'(wide_b), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
